// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI scan-out path.
// Holds 640x480@60 timing defaults, game-screen geometry, pixel/index types
// and the game-row successor helper used by the swap scheduler.
package hdmi_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int GAME_W = 320;
    localparam int GAME_H = 240;

    typedef logic [23:0] rgb_t;
    typedef logic [8:0]  pal_idx_t;

    // Row ppu_logic renders after the given row becomes visible; wraps to 0
    // after the last game row so the top row is ready for the next frame.
    function automatic logic [7:0] row_after(input logic [7:0] r);
        return (r == 8'(GAME_H - 1)) ? 8'd0 : r + 8'd1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and raw (stage-0) timing for the HDMI scan-out path.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   h_nxt, v_nxt      counter values that will be loaded on the next edge
//   active            h/v inside the visible window (current position)
//   hsync_n, vsync_n  raw active-low syncs (current position)
// Reset position is the first blank line (h=0, v=V_ACTIVE).
module vga_timing_gen
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_nxt,
    output logic [9:0] v_nxt,
    output logic       active,
    output logic       hsync_n,
    output logic       vsync_n
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h, v;

    always_comb begin
        h_nxt = h + 10'd1;
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= VA;
        end else begin
            h <= h_nxt;
            v <= v_nxt;
        end
    end

    assign active  = (h < HA) && (v < VA);
    assign hsync_n = !((h >= HS_BEG) && (h < HS_END));
    assign vsync_n = !((v >= VS_BEG) && (v < VS_END));

endmodule

// File: rtl/hdmi_row_scanner.sv
// 640x480 scan-out of the 320x240 game screen held in ppu_logic's row RAM.
// Each game pixel is shown 2x2: the row RAM address is h/2 and every game
// row is displayed on two consecutive lines, with a buffer swap issued at the
// end of the second line so ppu_logic renders one row ahead.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   hdmi_rowram_rdaddr    row RAM address (game x), registered
//   hdmi_rowram_rddata    palette index, 1 cycle after address
//   hdmi_palram_rdaddr    palette RAM address (= rowram data, combinational)
//   hdmi_palram_rddata    RGB888, 1 cycle after address
//   rowram_swap/next_row  buffer swap pulse and row to render next
//   o_rgb/o_hsync/o_vsync/o_de  registered TMDS-encoder inputs
// Counter-to-pin latency is 3 cycles for both pixel data and syncs.
module hdmi_row_scanner
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [8:0]  hdmi_rowram_rdaddr,
    input  logic [8:0]  hdmi_rowram_rddata,
    output logic [8:0]  hdmi_palram_rdaddr,
    input  logic [23:0] hdmi_palram_rddata,
    output logic        rowram_swap,
    output logic [7:0]  next_row,
    output logic [23:0] o_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de
);

    localparam int     STAGES  = 2;
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA      = 10'(H_ACTIVE);
    localparam logic [9:0] VA      = 10'(V_ACTIVE);
    localparam logic [9:0] V_SWMAX = 10'(V_ACTIVE - 3);

    logic [9:0] h_nxt, v_nxt;
    logic       active, hsync_n, vsync_n;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .h_nxt   (h_nxt),
        .v_nxt   (v_nxt),
        .active  (active),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n)
    );

    // Address is computed from the counter's next value so the registered
    // address lines up with h itself; this is what keeps the total latency
    // at 3 cycles instead of 4.
    logic act_nxt;
    assign act_nxt = (h_nxt < HA) && (v_nxt < VA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hdmi_rowram_rdaddr <= '0;
        else        hdmi_rowram_rdaddr <= act_nxt ? h_nxt[9:1] : 9'd0;
    end

    assign hdmi_palram_rdaddr = pal_idx_t'(hdmi_rowram_rddata);

    // Stage valid/sync shift registers. Syncs are carried active-high so the
    // cleared reset value means "not in sync" and the pins stay high.
    logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            o_rgb    <= '0;
            o_de     <= 1'b0;
            o_hsync  <= 1'b1;
            o_vsync  <= 1'b1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], active};
            hs_pipe  <= {hs_pipe[STAGES-1:1], ~hsync_n};
            vs_pipe  <= {vs_pipe[STAGES-1:1], ~vsync_n};
            o_rgb    <= vld_pipe[STAGES] ? rgb_t'(hdmi_palram_rddata) : rgb_t'(0);
            o_de     <= vld_pipe[STAGES];
            o_hsync  <= ~hs_pipe[STAGES];
            o_vsync  <= ~vs_pipe[STAGES];
        end
    end

    // Swap scheduler, also evaluated on the next position so the pulse is
    // high while h sits at the last pixel of the line. Odd lines end the
    // second copy of a game row; the line before active video starts row 0.
    // The final active line gets no swap: row 0 was queued at v=V_ACTIVE-3
    // and stays pending across vblank.
    logic       sched;
    logic [7:0] sched_row;

    always_comb begin
        sched     = 1'b0;
        sched_row = next_row;
        if (h_nxt == H_LAST) begin
            if (v_nxt[0] && (v_nxt <= V_SWMAX)) begin
                sched     = 1'b1;
                sched_row = row_after(8'((v_nxt + 10'd1) >> 1));
            end else if (v_nxt == V_LAST) begin
                sched     = 1'b1;
                sched_row = 8'd1;
            end
        end
    end

    // One-shot priming swap right after reset so row 0 is rendered during
    // the blank lines that follow the reset position.
    logic prime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime       <= 1'b1;
            rowram_swap <= 1'b0;
            next_row    <= '0;
        end else if (prime) begin
            prime       <= 1'b0;
            rowram_swap <= 1'b1;
            next_row    <= '0;
        end else begin
            rowram_swap <= sched;
            if (sched) next_row <= sched_row;
        end
    end

endmodule

// File: tb/tb_hdmi_row_scanner.sv
module tb_hdmi_row_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default 640x480 timing.
    logic        rst_n;
    logic [8:0]  ra_addr, pa_addr;
    logic [8:0]  ra_q;
    logic [23:0] pa_q;
    logic        swap, hs, vs, de;
    logic [7:0]  nrow;
    logic [23:0] rgb;

    hdmi_row_scanner dut (
        .clk(clk), .rst_n(rst_n),
        .hdmi_rowram_rdaddr(ra_addr), .hdmi_rowram_rddata(ra_q),
        .hdmi_palram_rdaddr(pa_addr), .hdmi_palram_rddata(pa_q),
        .rowram_swap(swap), .next_row(nrow),
        .o_rgb(rgb), .o_hsync(hs), .o_vsync(vs), .o_de(de)
    );

    // Second instance: 12-clock lines so full frames fit in a short run.
    logic        rst2_n;
    logic [8:0]  ra_addr2, pa_addr2;
    logic [8:0]  ra_q2;
    logic [23:0] pa_q2;
    logic        swap2, hs2, vs2, de2;
    logic [7:0]  nrow2;
    logic [23:0] rgb2;

    hdmi_row_scanner #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .hdmi_rowram_rdaddr(ra_addr2), .hdmi_rowram_rddata(ra_q2),
        .hdmi_palram_rdaddr(pa_addr2), .hdmi_palram_rddata(pa_q2),
        .rowram_swap(swap2), .next_row(nrow2),
        .o_rgb(rgb2), .o_hsync(hs2), .o_vsync(vs2), .o_de(de2)
    );

    // Memory models: row RAM returns its address, palette returns {0,index}.
    always @(posedge clk) begin
        ra_q  <= ra_addr;
        pa_q  <= {15'b0, pa_addr};
        ra_q2 <= ra_addr2;
        pa_q2 <= {15'b0, pa_addr2};
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel1  = 0;
    int rel2  = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          k;
        logic        swap;
        logic [7:0]  row;
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tbl[17];

    task automatic run_vecs(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            while (cyc - rel1 < tbl[i].k) step();
            chk($sformatf("v%0d.swap", tbl[i].k), swap, tbl[i].swap);
            chk($sformatf("v%0d.row",  tbl[i].k), nrow, tbl[i].row);
            chk($sformatf("v%0d.de",   tbl[i].k), de,   tbl[i].de);
            chk($sformatf("v%0d.rgb",  tbl[i].k), rgb,  tbl[i].rgb);
            chk($sformatf("v%0d.hs",   tbl[i].k), hs,   tbl[i].hs);
            chk($sformatf("v%0d.vs",   tbl[i].k), vs,   tbl[i].vs);
        end
    endtask

    task automatic chk_reset2(input string nm);
        chk({nm, ".addr"}, ra_addr2, 0);
        chk({nm, ".swap"}, swap2, 0);
        chk({nm, ".row"},  nrow2, 0);
        chk({nm, ".rgb"},  rgb2, 0);
        chk({nm, ".de"},   de2, 0);
        chk({nm, ".hs"},   hs2, 1);
        chk({nm, ".vs"},   vs2, 1);
    endtask

    initial begin
        // k = cycles since reset release; position is v=480+k/800, h=k%800.
        //            k      swp row de rgb hs vs
        tbl[0]  = '{0,     0, 0, 0, 0, 1, 1};
        tbl[1]  = '{1,     1, 0, 0, 0, 1, 1};
        tbl[2]  = '{2,     0, 0, 0, 0, 1, 1};
        tbl[3]  = '{1458,  0, 0, 0, 0, 1, 1};
        tbl[4]  = '{1459,  0, 0, 0, 0, 0, 1};
        tbl[5]  = '{1554,  0, 0, 0, 0, 0, 1};
        tbl[6]  = '{1555,  0, 0, 0, 0, 1, 1};
        tbl[7]  = '{8002,  0, 0, 0, 0, 1, 1};
        tbl[8]  = '{8003,  0, 0, 0, 0, 1, 0};
        tbl[9]  = '{9602,  0, 0, 0, 0, 1, 0};
        tbl[10] = '{9603,  0, 0, 0, 0, 1, 1};
        tbl[11] = '{35998, 0, 0, 0, 0, 1, 1};
        tbl[12] = '{35999, 1, 1, 0, 0, 1, 1};
        tbl[13] = '{36000, 0, 1, 0, 0, 1, 1};
        tbl[14] = '{36002, 0, 1, 0, 0, 1, 1};
        tbl[15] = '{37599, 1, 2, 0, 0, 1, 1};
        tbl[16] = '{37600, 0, 2, 0, 0, 1, 1};

        rst_n  = 1'b0;
        rst2_n = 1'b0;
        step();
        step();
        chk("rst.addr", ra_addr, 0);
        chk("rst.swap", swap, 0);
        chk("rst.row",  nrow, 0);
        chk("rst.rgb",  rgb, 0);
        chk("rst.de",   de, 0);
        chk("rst.hs",   hs, 1);
        chk("rst.vs",   vs, 1);

        rst_n = 1'b1;
        rel1  = cyc;
        run_vecs(0, 2);

        begin
            int n = 0;
            while (cyc - rel1 < 802) begin
                step();
                if (swap) n++;
            end
            chk("no_extra_swap", n, 0);
        end

        run_vecs(3, 6);

        // hsync width on line v=482 (starts at k=1600)
        begin
            int n = 0;
            int first = -1;
            while (cyc - rel1 < 2400) begin
                step();
                if (cyc - rel1 >= 2200 && !hs) begin
                    if (first < 0) first = cyc - rel1;
                    n++;
                end
            end
            chk("hs.width", n, 96);
            chk("hs.start", first, 2259);
        end

        run_vecs(7, 14);

        // First visible line: 2x horizontal pixel doubling.
        while (cyc - rel1 < 36003) step();
        for (int i = 0; i < 640; i++) begin
            chk($sformatf("pix%0d.de", i), de, 1);
            chk($sformatf("pix%0d.rgb", i), rgb, i >> 1);
            step();
        end
        chk("pix_end.de", de, 0);
        chk("pix_end.rgb", rgb, 0);

        run_vecs(15, 16);

        // Next swap two lines later.
        begin
            int pk = -1;
            while (cyc - rel1 < 40000) begin
                step();
                if (swap) begin
                    pk = cyc - rel1;
                    break;
                end
            end
            chk("period", pk - 37599, 1600);
            chk("period.row", nrow, 3);
        end

        // ---- Short-line instance: full-frame schedule, mid-frame reset ----
        chk_reset2("rst2");
        rst2_n = 1'b1;
        rel2   = cyc;
        step();
        chk("prime2.swap", swap2, 1);
        chk("prime2.row",  nrow2, 0);
        begin
            int n = 0, badpos = 0, badint = 0, prev = -1, miss = 0;
            int seen[240];
            for (int i = 0; i < 240; i++) seen[i] = 0;
            while (cyc - rel2 < 6301) begin
                int k2;
                step();
                k2 = cyc - rel2;
                if (swap2) begin
                    n++;
                    if (nrow2 < 240) seen[nrow2]++;
                    if (k2 % 12 != 11) badpos++;
                    if (prev >= 0 && k2 - prev != 24) badint++;
                    prev = k2;
                end
                if (k2 == 539)  begin chk("f.v524.swap", swap2, 1); chk("f.v524.row", nrow2, 1); end
                if (k2 == 551)  chk("f.v0.noswap", swap2, 0);
                if (k2 == 6275) begin chk("f.v477.swap", swap2, 1); chk("f.v477.row", nrow2, 0); end
                if (k2 == 6299) chk("f.v479.noswap", swap2, 0);
            end
            for (int i = 0; i < 240; i++) if (seen[i] != 1) miss++;
            chk("f.count", n, 240);
            chk("f.rows_once", miss, 0);
            chk("f.pos", badpos, 0);
            chk("f.interval", badint, 0);
        end

        // Mid-frame reset at v=100, h=5 of the second frame.
        while (cyc - rel2 < 6300 + 145 * 12 + 5) step();
        chk("mid.de",  de2, 1);
        chk("mid.rgb", rgb2, 1);
        chk("mid.row", nrow2, 51);
        #2 rst2_n = 1'b0;
        #1;
        chk_reset2("async");
        step();
        step();
        chk_reset2("held");
        rst2_n = 1'b1;
        rel2   = cyc;
        step();
        chk("reprime.swap", swap2, 1);
        chk("reprime.row",  nrow2, 0);
        begin
            int n = 0;
            while (cyc - rel2 < 538) begin
                step();
                if (swap2) n++;
            end
            chk("resume.quiet", n, 0);
            step();
            chk("resume.swap", swap2, 1);
            chk("resume.row",  nrow2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
